// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: memory read port on one side, decoder handshake
// and branch redirect on the other.
interface fetch_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic       mem_busy;
  logic [7:0] instr;
  logic [7:0] operand;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [7:0] branch_addr;
  logic [7:0] pc;

  modport master (
    output mem_addr,
    input  mem_q,
    input  mem_busy,
    output instr,
    output operand,
    output instr_valid,
    input  instr_ready,
    input  branch_taken,
    input  branch_addr,
    output pc
  );

  modport slave (
    input  mem_addr,
    output mem_q,
    input  mem_busy,
    input  instr,
    input  operand,
    input  instr_valid,
    output instr_ready,
    output branch_taken,
    output branch_addr,
    input  pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch for the 8-bit RISC-SPM core: reads 1- or 2-byte
// instructions from a 1-cycle-latency memory and presents them to the decoder.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [15:0] LONG_OPS = 16'b0000_0001_1110_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  typedef enum logic [2:0] {
    FETCH_OP,
    CAP_OP,
    FETCH_ARG,
    CAP_ARG,
    HOLD
  } state_t;

  state_t     state;
  logic [7:0] pc_r;
  logic [7:0] instr_r;
  logic [7:0] operand_r;
  logic       valid_r;

  function automatic logic has_operand(input logic [7:0] opcode);
    return LONG_OPS[opcode[7:4]];
  endfunction

  // In CAP_OP the operand read is issued early so a long instruction costs
  // only one extra cycle; pc itself advances on the same edge.
  assign bus.mem_addr    = (state == CAP_OP) ? pc_r + 8'd1 : pc_r;
  assign bus.instr       = instr_r;
  assign bus.operand     = operand_r;
  assign bus.instr_valid = valid_r;
  assign bus.pc          = pc_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH_OP;
      pc_r      <= RESET_PC;
      instr_r   <= 8'h00;
      operand_r <= 8'h00;
      valid_r   <= 1'b0;
    end else if (bus.branch_taken) begin
      pc_r    <= bus.branch_addr;
      state   <= FETCH_OP;
      valid_r <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (!bus.mem_busy) state <= CAP_OP;
        end
        CAP_OP: begin
          instr_r <= bus.mem_q;
          pc_r    <= pc_r + 8'd1;
          if (!has_operand(bus.mem_q)) begin
            operand_r <= 8'h00;
            state     <= HOLD;
            valid_r   <= 1'b1;
          end else if (!bus.mem_busy) begin
            state <= CAP_ARG;
          end else begin
            state <= FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          if (!bus.mem_busy) state <= CAP_ARG;
        end
        CAP_ARG: begin
          operand_r <= bus.mem_q;
          pc_r      <= pc_r + 8'd1;
          state     <= HOLD;
          valid_r   <= 1'b1;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            state   <= FETCH_OP;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH_OP;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256x8 synchronous-read memory.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] mem [256];
  logic [7:0] mem_q_r;
  int passed = 0;
  int total  = 0;

  fetch_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory samples mem_addr only when not busy; mem_q holds otherwise.
  always @(posedge clk) if (!bus.mem_busy) mem_q_r <= mem[bus.mem_addr];
  assign bus.mem_q = mem_q_r;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 8'h00) $display("FAIL reset_instr got %h exp 00", bus.instr); else passed++;
    total++; if (bus.operand !== 8'h00) $display("FAIL reset_operand got %h exp 00", bus.operand); else passed++;
    total++; if (bus.pc !== 8'h00) $display("FAIL reset_pc got %h exp 00", bus.pc); else passed++;
    total++; if (bus.mem_addr !== 8'h00) $display("FAIL reset_addr got %h exp 00", bus.mem_addr); else passed++;
  endtask

  task automatic test_short;
    mem[8'h00] = 8'h1C;
    rst_n = 1'b1;
    step;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL short_valid1 got %b exp 0", bus.instr_valid); else passed++;
    total++; if (bus.mem_addr !== 8'h01) $display("FAIL short_addr1 got %h exp 01", bus.mem_addr); else passed++;
    step;
    total++; if (bus.instr_valid !== 1'b1) $display("FAIL short_valid2 got %b exp 1", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 8'h1C) $display("FAIL short_instr got %h exp 1C", bus.instr); else passed++;
    total++; if (bus.operand !== 8'h00) $display("FAIL short_operand got %h exp 00", bus.operand); else passed++;
    total++; if (bus.pc !== 8'h01) $display("FAIL short_pc got %h exp 01", bus.pc); else passed++;
  endtask

  task automatic test_long;
    mem[8'h00] = 8'h50;
    mem[8'h01] = 8'h2A;
    rst_n = 1'b0;
    step;
    total++; if (bus.mem_addr !== 8'h00) $display("FAIL long_addr0 got %h exp 00", bus.mem_addr); else passed++;
    rst_n = 1'b1;
    step;
    total++; if (bus.mem_addr !== 8'h01) $display("FAIL long_addr1 got %h exp 01", bus.mem_addr); else passed++;
    step;
    total++; if (bus.mem_addr !== 8'h01 || bus.pc !== 8'h01) $display("FAIL long_addr2 got addr %h pc %h exp 01 01", bus.mem_addr, bus.pc); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL long_valid2 got %b exp 0", bus.instr_valid); else passed++;
    step;
    total++; if (bus.instr_valid !== 1'b1) $display("FAIL long_valid3 got %b exp 1", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 8'h50) $display("FAIL long_instr got %h exp 50", bus.instr); else passed++;
    total++; if (bus.operand !== 8'h2A) $display("FAIL long_operand got %h exp 2A", bus.operand); else passed++;
    total++; if (bus.pc !== 8'h02 || bus.mem_addr !== 8'h02) $display("FAIL long_pc got pc %h addr %h exp 02 02", bus.pc, bus.mem_addr); else passed++;
  endtask

  task automatic test_hold;
    mem[8'h02] = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step;
      total++;
      if ({bus.instr_valid, bus.instr, bus.operand, bus.pc} !== {1'b1, 8'h50, 8'h2A, 8'h02})
        $display("FAIL hold_cycle%0d got v%b %h %h %h exp v1 50 2A 02", i, bus.instr_valid, bus.instr, bus.operand, bus.pc);
      else passed++;
    end
    bus.instr_ready = 1'b1;
    step;
    bus.instr_ready = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL hold_drop got %b exp 0", bus.instr_valid); else passed++;
    total++; if (bus.mem_addr !== 8'h02) $display("FAIL hold_next_addr got %h exp 02", bus.mem_addr); else passed++;
    step;
    step;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 8'h0F || bus.pc !== 8'h03)
      $display("FAIL hold_next got v%b %h pc %h exp v1 0F 03", bus.instr_valid, bus.instr, bus.pc); else passed++;
  endtask

  task automatic test_busy;
    mem[8'h03] = 8'h70;
    mem[8'h04] = 8'hA5;
    bus.instr_ready = 1'b1;
    step;
    bus.instr_ready = 1'b0;
    bus.mem_busy = 1'b1;
    step;
    step;
    total++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 8'h03) $display("FAIL busy_op_stall got v%b addr %h exp v0 03", bus.instr_valid, bus.mem_addr); else passed++;
    bus.mem_busy = 1'b0;
    step;
    bus.mem_busy = 1'b1;
    step;
    total++; if (bus.instr !== 8'h70 || bus.pc !== 8'h04 || bus.mem_addr !== 8'h04)
      $display("FAIL busy_capop got %h pc %h addr %h exp 70 04 04", bus.instr, bus.pc, bus.mem_addr); else passed++;
    step;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL busy_arg_stall got %b exp 0", bus.instr_valid); else passed++;
    bus.mem_busy = 1'b0;
    step;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL busy_caparg_valid got %b exp 0", bus.instr_valid); else passed++;
    step;
    total++; if ({bus.instr_valid, bus.instr, bus.operand, bus.pc} !== {1'b1, 8'h70, 8'hA5, 8'h05})
      $display("FAIL busy_result got v%b %h %h %h exp v1 70 A5 05", bus.instr_valid, bus.instr, bus.operand, bus.pc); else passed++;
  endtask

  task automatic test_branch;
    mem[8'h05] = 8'h60;
    mem[8'h06] = 8'h11;
    mem[8'h80] = 8'h2B;
    bus.instr_ready = 1'b1;
    step;
    bus.instr_ready = 1'b0;
    step;
    step;
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 8'h80;
    step;
    bus.branch_taken = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.pc !== 8'h80 || bus.mem_addr !== 8'h80)
      $display("FAIL branch_redirect got v%b pc %h addr %h exp v0 80 80", bus.instr_valid, bus.pc, bus.mem_addr); else passed++;
    step;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL branch_no_stale got %b exp 0", bus.instr_valid); else passed++;
    step;
    total++; if ({bus.instr_valid, bus.instr, bus.operand, bus.pc} !== {1'b1, 8'h2B, 8'h00, 8'h81})
      $display("FAIL branch_target got v%b %h %h %h exp v1 2B 00 81", bus.instr_valid, bus.instr, bus.operand, bus.pc); else passed++;
  endtask

  task automatic test_wrap_and_reset;
    mem[8'hFF] = 8'h60;
    mem[8'h00] = 8'h33;
    bus.instr_ready  = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 8'hFF;
    step;
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.pc !== 8'hFF) $display("FAIL wrap_redirect got v%b pc %h exp v0 FF", bus.instr_valid, bus.pc); else passed++;
    step;
    total++; if (bus.mem_addr !== 8'h00) $display("FAIL wrap_addr got %h exp 00", bus.mem_addr); else passed++;
    step;
    step;
    total++; if ({bus.instr_valid, bus.instr, bus.operand, bus.pc} !== {1'b1, 8'h60, 8'h33, 8'h01})
      $display("FAIL wrap_result got v%b %h %h %h exp v1 60 33 01", bus.instr_valid, bus.instr, bus.operand, bus.pc); else passed++;
    bus.instr_ready = 1'b1;
    step;
    bus.instr_ready = 1'b0;
    step;
    rst_n = 1'b0;
    step;
    total++; if ({bus.instr_valid, bus.instr, bus.operand, bus.pc, bus.mem_addr} !== {1'b0, 8'h00, 8'h00, 8'h00, 8'h00})
      $display("FAIL midfetch_reset got v%b %h %h pc %h addr %h exp v0 00 00 00 00",
               bus.instr_valid, bus.instr, bus.operand, bus.pc, bus.mem_addr); else passed++;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_q_r          = 8'h00;
    rst_n            = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 8'h00;
    test_reset;
    test_short;
    test_long;
    test_hold;
    test_busy;
    test_branch;
    test_wrap_and_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
